// File: rtl/cache_snoop_resp_pkg.sv
// Shared coherence-bus types for the two-core MSI system, plus snoop responder FSM states.
package cache_snoop_resp_pkg;

    typedef enum logic [2:0] {
        NOOP,
        READ_MISS_0,
        READ_MISS_1,
        WRITE_MISS_0,
        WRITE_MISS_1,
        INVALIDATE_0,
        INVALIDATE_1
    } bus_op_t;

    typedef enum logic [1:0] {
        INVALID,
        SHARED,
        MODIFIED
    } cache_block_state_t;

    typedef enum logic [2:0] {
        SN_IDLE,
        SN_LOOKUP,
        SN_COMPARE,
        SN_FLUSH,
        SN_UPDATE,
        SN_ACK,
        SN_WAIT_DROP
    } snoop_state_t;

    // Issuing core of a bus op; NOOP has no issuer and reports 0.
    function automatic logic op_core(input bus_op_t op);
        case (op)
            READ_MISS_1, WRITE_MISS_1, INVALIDATE_1: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cache_snoop_resp_sat_ctr.sv
// 16-bit saturating event counter used for snoop statistics.
module snoop_sat_ctr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/cache_snoop_resp.sv
// Snoop responder for one core's private MSI data cache on the two-core coherence bus.
// Optional statistics counters are built only when SNOOP_STATS_EN is defined.
module cache_snoop_resp
    import cache_snoop_resp_pkg::*;
#(
    parameter int CORE_ID = 0,
    parameter int INDEX_W = 4,
    localparam int TAG_W = 16 - INDEX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bus_valid,
    input  bus_op_t            bus_op,
    input  logic [15:0]        bus_addr,
    output logic               snoop_ack,
    output logic [INDEX_W-1:0] arr_rd_idx,
    input  logic [TAG_W-1:0]   arr_rd_tag,
    input  cache_block_state_t arr_rd_state,
    input  logic [15:0]        arr_rd_data,
    output logic               arr_wr_en,
    output logic [INDEX_W-1:0] arr_wr_idx,
    output cache_block_state_t arr_wr_state,
    output logic               flush_valid,
    output logic [15:0]        flush_addr,
    output logic [15:0]        flush_data,
    input  logic               flush_ready,
    output logic               proto_err,
    output logic [15:0]        stat_flush_cnt,
    output logic [15:0]        stat_inv_cnt
);

    localparam logic SELF_ID = 1'(CORE_ID);

    snoop_state_t       state, state_nx;
    bus_op_t            op_q;
    logic [15:0]        addr_q, data_q;
    cache_block_state_t wr_state_q, act_state;
    logic               illegal_q, act_illegal, act_flush, act_write;
    logic               hit, bypass;

    assign bypass = (bus_op == NOOP) || (op_core(bus_op) == SELF_ID);
    assign hit    = (arr_rd_tag == addr_q[15:INDEX_W]) && (arr_rd_state != INVALID);

    // MSI response table; only peer-issued ops ever reach COMPARE.
    always_comb begin
        act_flush   = 1'b0;
        act_write   = 1'b0;
        act_illegal = 1'b0;
        act_state   = arr_rd_state;
        if (hit) begin
            case (op_q)
                READ_MISS_0, READ_MISS_1: begin
                    if (arr_rd_state == MODIFIED) begin
                        act_flush = 1'b1;
                        act_write = 1'b1;
                        act_state = SHARED;
                    end
                end
                WRITE_MISS_0, WRITE_MISS_1: begin
                    act_flush = (arr_rd_state == MODIFIED);
                    act_write = 1'b1;
                    act_state = INVALID;
                end
                INVALIDATE_0, INVALIDATE_1: begin
                    act_illegal = (arr_rd_state == MODIFIED);
                    act_write   = 1'b1;
                    act_state   = INVALID;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SN_IDLE;
            op_q       <= NOOP;
            addr_q     <= '0;
            data_q     <= '0;
            wr_state_q <= INVALID;
            illegal_q  <= 1'b0;
            arr_rd_idx <= '0;
        end else begin
            state <= state_nx;
            case (state)
                SN_IDLE: begin
                    if (bus_valid) begin
                        op_q   <= bus_op;
                        addr_q <= bus_addr;
                        if (!bypass) begin
                            arr_rd_idx <= bus_addr[INDEX_W-1:0];
                        end
                    end
                end
                SN_COMPARE: begin
                    data_q     <= arr_rd_data;
                    wr_state_q <= act_state;
                    illegal_q  <= act_illegal;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            SN_IDLE:      if (bus_valid) state_nx = bypass ? SN_ACK : SN_LOOKUP;
            SN_LOOKUP:    state_nx = SN_COMPARE;
            SN_COMPARE: begin
                if (act_flush)      state_nx = SN_FLUSH;
                else if (act_write) state_nx = SN_UPDATE;
                else                state_nx = SN_ACK;
            end
            SN_FLUSH:     if (flush_ready) state_nx = SN_UPDATE;
            SN_UPDATE:    state_nx = SN_ACK;
            SN_ACK:       state_nx = SN_WAIT_DROP;
            SN_WAIT_DROP: if (!bus_valid) state_nx = SN_IDLE;
            default:      state_nx = SN_IDLE;
        endcase
    end

    assign snoop_ack    = (state == SN_ACK);
    assign flush_valid  = (state == SN_FLUSH);
    assign flush_addr   = flush_valid ? addr_q : '0;
    assign flush_data   = flush_valid ? data_q : '0;
    assign arr_wr_en    = (state == SN_UPDATE);
    assign arr_wr_idx   = arr_wr_en ? addr_q[INDEX_W-1:0] : '0;
    assign arr_wr_state = wr_state_q;
    assign proto_err    = arr_wr_en && illegal_q;

`ifdef SNOOP_STATS_EN
    snoop_sat_ctr u_flush_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_valid && flush_ready),
        .count (stat_flush_cnt)
    );

    snoop_sat_ctr u_inv_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (arr_wr_en && (wr_state_q == INVALID)),
        .count (stat_inv_cnt)
    );
`else
    assign stat_flush_cnt = '0;
    assign stat_inv_cnt   = '0;
`endif

endmodule

// File: tb/tb_cache_snoop_resp.sv
// Self-checking bench for cache_snoop_resp (CORE_ID=0, INDEX_W=4) with a behavioural tag/state array.
module tb_cache_snoop_resp;
    import cache_snoop_resp_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               bus_valid = 1'b0;
    bus_op_t            bus_op = NOOP;
    logic [15:0]        bus_addr = '0;
    logic               snoop_ack;
    logic [3:0]         arr_rd_idx;
    logic [11:0]        arr_rd_tag;
    cache_block_state_t arr_rd_state;
    logic [15:0]        arr_rd_data;
    logic               arr_wr_en;
    logic [3:0]         arr_wr_idx;
    cache_block_state_t arr_wr_state;
    logic               flush_valid;
    logic [15:0]        flush_addr, flush_data;
    logic               flush_ready = 1'b0;
    logic               proto_err;
    logic [15:0]        stat_flush_cnt, stat_inv_cnt;

    cache_snoop_resp #(.CORE_ID(0), .INDEX_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
        .snoop_ack(snoop_ack), .arr_rd_idx(arr_rd_idx), .arr_rd_tag(arr_rd_tag),
        .arr_rd_state(arr_rd_state), .arr_rd_data(arr_rd_data), .arr_wr_en(arr_wr_en),
        .arr_wr_idx(arr_wr_idx), .arr_wr_state(arr_wr_state), .flush_valid(flush_valid),
        .flush_addr(flush_addr), .flush_data(flush_data), .flush_ready(flush_ready),
        .proto_err(proto_err), .stat_flush_cnt(stat_flush_cnt), .stat_inv_cnt(stat_inv_cnt)
    );

    always #5 clk = ~clk;

    // Cache array: contents written only by the initial-block process; read port is registered.
    logic [11:0]        tag_mem [16];
    cache_block_state_t st_mem  [16];
    logic [15:0]        dat_mem [16];

    always @(posedge clk) begin
        arr_rd_tag   <= tag_mem[arr_rd_idx];
        arr_rd_state <= st_mem[arr_rd_idx];
        arr_rd_data  <= dat_mem[arr_rd_idx];
    end

    int checks = 0;
    int errors = 0;

    // Observations of one transaction, cycle numbers relative to the accepting edge.
    int o_ack_n, o_ack_k, o_wr_n, o_wr_k, o_fl_n, o_pe_n, o_pe_k;
    cache_block_state_t o_wr_st;
    logic [15:0] o_fl_addr, o_fl_data;

    // Reference expectations.
    bit e_bypass, e_flush, e_write, e_proto;
    cache_block_state_t e_state;
    int e_ack_k, e_wr_k;

    task automatic preload(input int idx, input logic [11:0] tag, input cache_block_state_t st,
                           input logic [15:0] data);
        tag_mem[idx] = tag;
        st_mem[idx]  = st;
        dat_mem[idx] = data;
    endtask

    task automatic predict(input bus_op_t op, input logic [15:0] addr, input int stall);
        int  idx;
        bit  hit, from_peer;
        cache_block_state_t cur;
        idx       = int'(addr[3:0]);
        cur       = st_mem[idx];
        hit       = (tag_mem[idx] == addr[15:4]) && (cur != INVALID);
        from_peer = (op == READ_MISS_1) || (op == WRITE_MISS_1) || (op == INVALIDATE_1);
        e_bypass = !from_peer;
        e_flush  = 0;
        e_write  = 0;
        e_proto  = 0;
        e_state  = cur;
        if (from_peer && hit) begin
            if (op == READ_MISS_1 && cur == MODIFIED) begin
                e_flush = 1; e_write = 1; e_state = SHARED;
            end else if (op == WRITE_MISS_1) begin
                e_flush = (cur == MODIFIED); e_write = 1; e_state = INVALID;
            end else if (op == INVALIDATE_1) begin
                e_proto = (cur == MODIFIED); e_write = 1; e_state = INVALID;
            end
        end
        if (e_bypass)     begin e_ack_k = 1;         e_wr_k = -1;        end
        else if (e_flush) begin e_ack_k = 5 + stall; e_wr_k = 4 + stall; end
        else if (e_write) begin e_ack_k = 4;         e_wr_k = 3;         end
        else              begin e_ack_k = 3;         e_wr_k = -1;        end
    endtask

    task automatic run_txn(input bus_op_t op, input logic [15:0] addr, input int stall, input int hold);
        int drop_k;
        @(negedge clk);
        bus_op = op; bus_addr = addr; bus_valid = 1'b1; flush_ready = 1'b0;
        o_ack_n = 0; o_ack_k = -1; o_wr_n = 0; o_wr_k = -1; o_fl_n = 0; o_pe_n = 0; o_pe_k = -1;
        o_wr_st = INVALID; o_fl_addr = '0; o_fl_data = '0; drop_k = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (snoop_ack) begin
                o_ack_n++;
                if (o_ack_k < 0) begin o_ack_k = k; drop_k = k + hold; end
            end
            if (arr_wr_en) begin
                o_wr_n++; o_wr_k = k; o_wr_st = arr_wr_state;
                st_mem[arr_wr_idx] = arr_wr_state;
            end
            if (flush_valid) begin
                o_fl_n++; o_fl_addr = flush_addr; o_fl_data = flush_data;
            end
            flush_ready = flush_valid && (o_fl_n > stall);
            if (proto_err) begin o_pe_n++; o_pe_k = k; end
            if (k == drop_k) bus_valid = 1'b0;
        end
        bus_valid = 1'b0; flush_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({snoop_ack, arr_wr_en, flush_valid, proto_err, arr_rd_idx, arr_wr_idx, arr_wr_state,
             flush_addr, flush_data, stat_flush_cnt, stat_inv_cnt} !== '0) begin
            errors++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({snoop_ack, arr_wr_en, flush_valid, proto_err} !== 4'b0) begin
            errors++; $display("FAIL idle_outputs: got %b required 0000", {snoop_ack, arr_wr_en, flush_valid, proto_err});
        end
    endtask

    task automatic test_flush_read;
        preload(3, 12'h0AB, MODIFIED, 16'hBEEF);
        run_txn(READ_MISS_1, 16'h0AB3, 2, 0);
        checks++; if (o_fl_addr !== 16'h0AB3) begin errors++; $display("FAIL flush_addr: got %h required 0ab3", o_fl_addr); end
        checks++; if (o_fl_data !== 16'hBEEF) begin errors++; $display("FAIL flush_data: got %h required beef", o_fl_data); end
        checks++; if (o_fl_n !== 3) begin errors++; $display("FAIL flush_cycles: got %0d required 3", o_fl_n); end
        checks++; if (o_wr_k !== 6 || o_wr_st !== SHARED) begin
            errors++; $display("FAIL flush_write: got cycle %0d state %0d required cycle 6 state SHARED", o_wr_k, o_wr_st); end
        checks++; if (o_ack_k !== 7 || o_ack_n !== 1) begin
            errors++; $display("FAIL flush_ack: got cycle %0d count %0d required cycle 7 count 1", o_ack_k, o_ack_n); end
    endtask

    task automatic test_write_miss_shared;
        run_txn(WRITE_MISS_1, 16'h0AB3, 0, 0);
        checks++; if (o_fl_n !== 0) begin errors++; $display("FAIL wm_noflush: got %0d flush cycles required 0", o_fl_n); end
        checks++; if (o_wr_k !== 3 || o_wr_st !== INVALID) begin
            errors++; $display("FAIL wm_write: got cycle %0d state %0d required cycle 3 INVALID", o_wr_k, o_wr_st); end
        checks++; if (o_ack_k !== 4) begin errors++; $display("FAIL wm_ack: got %0d required 4", o_ack_k); end
    endtask

    task automatic test_self_issued;
        preload(3, 12'h0AB, MODIFIED, 16'hBEEF);
        run_txn(READ_MISS_0, 16'h0AB3, 0, 0);
        checks++; if (o_ack_k !== 1) begin errors++; $display("FAIL self_ack: got %0d required 1", o_ack_k); end
        checks++; if (o_wr_n !== 0 || o_fl_n !== 0) begin
            errors++; $display("FAIL self_noaction: got writes %0d flushes %0d required 0 0", o_wr_n, o_fl_n); end
    endtask

    task automatic test_invalidate_modified;
        preload(5, 12'h123, MODIFIED, 16'h5555);
        run_txn(INVALIDATE_1, 16'h1235, 0, 0);
        checks++; if (o_pe_n !== 1 || o_pe_k !== 3) begin
            errors++; $display("FAIL proto_err: got count %0d cycle %0d required 1 at 3", o_pe_n, o_pe_k); end
        checks++; if (o_fl_n !== 0) begin errors++; $display("FAIL inv_noflush: got %0d required 0", o_fl_n); end
        checks++; if (o_wr_st !== INVALID || st_mem[5] !== INVALID) begin
            errors++; $display("FAIL inv_state: got %0d required INVALID", st_mem[5]); end
        checks++; if (o_ack_k !== 4) begin errors++; $display("FAIL inv_ack: got %0d required 4", o_ack_k); end
    endtask

    task automatic test_hold_and_reset;
        bit saw_wr;
        preload(7, 12'h0AB, SHARED, 16'h0007);
        run_txn(WRITE_MISS_1, 16'h0AB7, 0, 5);
        checks++; if (o_ack_n !== 1 || o_ack_k !== 4) begin
            errors++; $display("FAIL held_ack: got count %0d cycle %0d required 1 at 4", o_ack_n, o_ack_k); end
        preload(9, 12'h0AB, MODIFIED, 16'h1234);
        @(negedge clk);
        bus_op = READ_MISS_1; bus_addr = 16'h0AB9; bus_valid = 1'b1; flush_ready = 1'b0; saw_wr = 0;
        repeat (4) begin @(negedge clk); if (arr_wr_en) saw_wr = 1; end
        checks++; if (flush_valid !== 1'b1) begin errors++; $display("FAIL rst_flush_pending: got %b required 1", flush_valid); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({snoop_ack, arr_wr_en, flush_valid, proto_err, flush_addr, flush_data, arr_wr_state} !== '0) begin
            errors++; $display("FAIL rst_in_flush: got outputs nonzero required all 0"); end
        rst_n = 1'b1; bus_valid = 1'b0;
        repeat (4) begin @(negedge clk); if (arr_wr_en) saw_wr = 1; end
        checks++; if (saw_wr !== 1'b0) begin errors++; $display("FAIL rst_no_write: got write %b required 0", saw_wr); end
    endtask

    task automatic test_stats;
        logic [15:0] ef, ei;
        preload(1, 12'h0AB, MODIFIED, 16'h1111); run_txn(WRITE_MISS_1, 16'h0AB1, 1, 0);
        preload(2, 12'h0AB, MODIFIED, 16'h2222); run_txn(WRITE_MISS_1, 16'h0AB2, 0, 0);
        preload(3, 12'h0AB, MODIFIED, 16'h3333); run_txn(READ_MISS_1,  16'h0AB3, 2, 0);
        preload(4, 12'h0AB, SHARED,   16'h4444); run_txn(WRITE_MISS_1, 16'h0AB4, 0, 0);
        preload(5, 12'h0AB, SHARED,   16'h5555); run_txn(INVALIDATE_1, 16'h0AB5, 0, 0);
`ifdef SNOOP_STATS_EN
        ef = 16'd3; ei = 16'd4;
`else
        ef = 16'd0; ei = 16'd0;
`endif
        checks++; if (stat_flush_cnt !== ef) begin errors++; $display("FAIL stat_flush: got %0d required %0d", stat_flush_cnt, ef); end
        checks++; if (stat_inv_cnt !== ei) begin errors++; $display("FAIL stat_inv: got %0d required %0d", stat_inv_cnt, ei); end
    endtask

    task automatic test_random;
        bus_op_t     op;
        logic [15:0] addr, edata;
        logic [11:0] tags [2];
        int          idx, stall, hold;
        tags[0] = 12'h0AB; tags[1] = 12'h0AC;
        for (int n = 0; n < 40; n++) begin
            idx   = int'($urandom_range(0, 15));
            addr  = {tags[$urandom_range(0, 1)], 4'(idx)};
            op    = bus_op_t'($urandom_range(0, 6));
            stall = int'($urandom_range(0, 3));
            hold  = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                preload(idx, tags[$urandom_range(0, 1)], cache_block_state_t'($urandom_range(0, 2)), 16'($urandom));
            edata = dat_mem[idx];
            predict(op, addr, stall);
            run_txn(op, addr, stall, hold);
            checks++; if (o_ack_k !== e_ack_k || o_ack_n !== 1) begin
                errors++; $display("FAIL rnd_ack[%0d]: got cycle %0d count %0d required cycle %0d count 1", n, o_ack_k, o_ack_n, e_ack_k); end
            checks++; if (o_wr_k !== e_wr_k || (e_write && o_wr_st !== e_state)) begin
                errors++; $display("FAIL rnd_write[%0d]: got cycle %0d state %0d required cycle %0d state %0d", n, o_wr_k, o_wr_st, e_wr_k, e_state); end
            checks++; if (o_fl_n !== (e_flush ? stall + 1 : 0)) begin
                errors++; $display("FAIL rnd_flush_n[%0d]: got %0d required %0d", n, o_fl_n, e_flush ? stall + 1 : 0); end
            if (e_flush) begin
                checks++; if (o_fl_addr !== addr || o_fl_data !== edata) begin
                    errors++; $display("FAIL rnd_flush_word[%0d]: got %h/%h required %h/%h", n, o_fl_addr, o_fl_data, addr, edata); end
            end
            checks++; if (o_pe_n !== int'(e_proto)) begin
                errors++; $display("FAIL rnd_proto[%0d]: got %0d required %0d", n, o_pe_n, e_proto); end
            checks++; if (st_mem[idx] !== e_state) begin
                errors++; $display("FAIL rnd_state[%0d]: got %0d required %0d", n, st_mem[idx], e_state); end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) preload(i, 12'h000, INVALID, 16'h0000);
        test_reset();
        test_flush_read();
        test_write_miss_shared();
        test_self_issued();
        test_invalidate_modified();
        test_hold_and_reset();
        test_stats();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
